poly_note_parser: RTL

POLY_NOTE_PARSER -- requirements
Module: poly_note_parser

---
 rtl/note_pkg.sv | 76 +++++++
 rtl/evt_fifo.sv | 70 +++++++
 rtl/poly_note_parser.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_pkg
// Description : Shared types and helpers for the polyphonic note parser:
//               keycode-to-note mapping, octave keycodes, FSM states and
//               the event record carried through the event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package note_pkg;

    localparam int NOTE_MAX    = 63;
    // Voice field is sized for up to 16 voices; the top truncates it.
    localparam int EVT_VOICE_W = 4;

    localparam logic [7:0]        c_KEY_OCT_DN = 8'h3A;
    localparam logic [7:0]        c_KEY_OCT_UP = 8'h3B;
    localparam logic signed [2:0] c_OCT_MIN    = 3'sb110;
    localparam logic signed [2:0] c_OCT_MAX    = 3'sb010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN_OFF = 2'd1,
        SCAN_ON  = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    typedef struct packed {
        logic                   on;
        logic [5:0]             note;
        logic [EVT_VOICE_W-1:0] voice;
    } evt_t;

    // Returns {hit, base}; base is the semitone offset 0..30 of the key.
    function automatic logic [5:0] key2note(input logic [7:0] key);
        logic [5:0] r;
        r = 6'd0;
        case (key)
            8'h1D: r = {1'b1, 5'd0};
            8'h1B: r = {1'b1, 5'd2};
            8'h06: r = {1'b1, 5'd4};
            8'h19: r = {1'b1, 5'd6};
            8'h05: r = {1'b1, 5'd8};
            8'h11: r = {1'b1, 5'd10};
            8'h10: r = {1'b1, 5'd12};
            8'h36: r = {1'b1, 5'd14};
            8'h37: r = {1'b1, 5'd16};
            8'h38: r = {1'b1, 5'd18};
            8'h04: r = {1'b1, 5'd5};
            8'h16: r = {1'b1, 5'd7};
            8'h07: r = {1'b1, 5'd9};
            8'h09: r = {1'b1, 5'd11};
            8'h0A: r = {1'b1, 5'd13};
            8'h0B: r = {1'b1, 5'd15};
            8'h0D: r = {1'b1, 5'd17};
            8'h0E: r = {1'b1, 5'd19};
            8'h0F: r = {1'b1, 5'd21};
            8'h33: r = {1'b1, 5'd23};
            8'h34: r = {1'b1, 5'd25};
            8'h14: r = {1'b1, 5'd10};
            8'h1A: r = {1'b1, 5'd12};
            8'h08: r = {1'b1, 5'd14};
            8'h15: r = {1'b1, 5'd16};
            8'h17: r = {1'b1, 5'd18};
            8'h1C: r = {1'b1, 5'd20};
            8'h18: r = {1'b1, 5'd22};
            8'h0C: r = {1'b1, 5'd24};
            8'h12: r = {1'b1, 5'd26};
            8'h13: r = {1'b1, 5'd28};
            8'h2F: r = {1'b1, 5'd30};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : evt_fifo
// Description : Synchronous FIFO for parser events. Power-of-two depth.
//               A push while full is accepted only when a pop happens in
//               the same cycle; a push into an empty FIFO becomes visible
//               one cycle later (no bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module evt_fifo
    import note_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = evt_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_data,
    output logic o_in_ready,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    localparam int c_AW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [c_AW-1:0] r_wr;
    logic [c_AW-1:0] r_rd;
    logic [c_AW:0]   r_count;

    logic w_full;
    logic w_pop;
    logic w_wr;

    // Handshake qualification; a pop frees a slot for a same-cycle push.
    always_comb begin
        w_full     = (r_count == (c_AW+1)'(DEPTH));
        w_pop      = i_ready && (r_count != '0);
        o_in_ready = !w_full || w_pop;
        w_wr       = i_push && o_in_ready;
        o_valid    = (r_count != '0);
        o_data     = r_mem[r_rd];
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/poly_note_parser.sv
`default_nettype none
// ============================================================================
// Module      : poly_note_parser
// Description : Turns HID keyboard reports into note-on/note-off events.
//               Each report is diffed against the previous one, one slot per
//               cycle: released keys free their voice, new keys claim the
//               lowest free voice. 3A/3B shift the octave. NUM_KEYS and
//               NUM_VOICES must be at least 2; NUM_VOICES at most 16.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_note_parser
    import note_pkg::*;
#(
    parameter int NUM_KEYS   = 6,
    parameter int NUM_VOICES = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [NUM_KEYS-1:0][7:0]      keycodes,
    input  logic                          report_valid,
    output logic                          busy,
    output logic                          report_drop,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          evt_on,
    output logic [5:0]                    evt_note,
    output logic [$clog2(NUM_VOICES)-1:0] evt_voice,
    output logic                          voice_full,
    output logic signed [2:0]             octave
);

    localparam int                c_VW      = $clog2(NUM_VOICES);
    localparam int                c_IW      = $clog2(NUM_KEYS);
    localparam logic [c_IW-1:0]   c_LAST    = c_IW'(NUM_KEYS - 1);
    localparam logic signed [7:0] c_NOTE_HI = 8'(NOTE_MAX);

    state_t                      r_state, w_next;
    logic [c_IW-1:0]             r_idx;
    logic [NUM_KEYS-1:0][7:0]    r_prev, r_new;
    logic [NUM_VOICES-1:0]       r_v_busy;
    logic [NUM_VOICES-1:0][7:0]  r_v_key;
    logic [NUM_VOICES-1:0][5:0]  r_v_note;
    logic signed [2:0]           r_octave;
    logic                        r_report_drop, r_voice_full;

    logic [NUM_KEYS-1:0][7:0]    w_own, w_other;
    logic [7:0]                  w_key;
    logic                        w_in_other, w_dup, w_fresh;
    logic [5:0]                  w_map;
    logic                        w_held_hit, w_free_hit;
    logic [c_VW-1:0]             w_held_v, w_free_v;
    logic signed [7:0]           w_oct_ext, w_note_s;
    logic [5:0]                  w_note_on;
    logic                        w_do_off, w_want_on, w_do_on, w_no_voice;
    logic                        w_oct_up, w_oct_dn;
    logic                        w_need_push, w_push, w_stall, w_in_ready;
    logic                        w_busy;
    evt_t                        w_push_data, w_head;
    logic                        w_head_valid;
    logic                        w_unused;

    // Examine the current slot: is it a fresh key, which voices match/are free.
    always_comb begin
        w_own      = (r_state == SCAN_OFF) ? r_prev : r_new;
        w_other    = (r_state == SCAN_OFF) ? r_new  : r_prev;
        w_key      = w_own[r_idx];
        w_in_other = 1'b0;
        w_dup      = 1'b0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            if (w_other[j] == w_key) w_in_other = 1'b1;
            if ((j < int'(r_idx)) && (w_own[j] == w_key)) w_dup = 1'b1;
        end
        w_fresh    = (w_key != 8'h00) && !w_in_other && !w_dup;

        w_held_hit = 1'b0;
        w_held_v   = '0;
        w_free_hit = 1'b0;
        w_free_v   = '0;
        // Descending walk leaves the lowest-numbered match in place.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_v_busy[v] && (r_v_key[v] == w_key)) begin
                w_held_hit = 1'b1;
                w_held_v   = c_VW'(v);
            end
            if (!r_v_busy[v]) begin
                w_free_hit = 1'b1;
                w_free_v   = c_VW'(v);
            end
        end

        w_map     = key2note(w_key);
        w_oct_ext = {{5{r_octave[2]}}, r_octave};
        w_note_s  = $signed({3'b000, w_map[4:0]}) + w_oct_ext * 8'sd12;
        if (w_note_s < 8'sd0)           w_note_on = 6'd0;
        else if (w_note_s > c_NOTE_HI)  w_note_on = 6'(NOTE_MAX);
        else                            w_note_on = w_note_s[5:0];

        w_do_off    = (r_state == SCAN_OFF) && w_fresh && w_map[5] && w_held_hit;
        w_want_on   = (r_state == SCAN_ON) && w_fresh && w_map[5];
        w_do_on     = w_want_on && w_free_hit;
        w_no_voice  = w_want_on && !w_free_hit;
        w_oct_up    = (r_state == SCAN_ON) && w_fresh && (w_key == c_KEY_OCT_UP);
        w_oct_dn    = (r_state == SCAN_ON) && w_fresh && (w_key == c_KEY_OCT_DN);

        w_need_push = w_do_off || w_do_on;
        w_push      = w_need_push && w_in_ready;
        w_stall     = w_need_push && !w_in_ready;

        w_push_data.on    = w_do_on;
        w_push_data.note  = w_do_on ? w_note_on : r_v_note[w_held_v];
        w_push_data.voice = EVT_VOICE_W'(w_do_on ? w_free_v : w_held_v);
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // FSM next-state: each scan phase ends after its last slot is handled.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (report_valid) w_next = SCAN_OFF;
            SCAN_OFF: if (!w_stall && (r_idx == c_LAST)) w_next = SCAN_ON;
            SCAN_ON:  if (!w_stall && (r_idx == c_LAST)) w_next = COMMIT;
            COMMIT:   w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_busy = (r_state != IDLE);
    end

    // Report capture, slot index, voice table, octave and status pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_idx         <= '0;
            r_prev        <= '0;
            r_new         <= '0;
            r_v_busy      <= '0;
            r_v_key       <= '0;
            r_v_note      <= '0;
            r_octave      <= 3'sb000;
            r_report_drop <= 1'b0;
            r_voice_full  <= 1'b0;
        end else begin
            r_report_drop <= report_valid && w_busy;
            r_voice_full  <= w_no_voice;
            case (r_state)
                IDLE: begin
                    if (report_valid) begin
                        r_new <= keycodes;
                        r_idx <= '0;
                    end
                end
                SCAN_OFF, SCAN_ON: begin
                    if (!w_stall) r_idx <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
                end
                COMMIT:  r_prev <= r_new;
                default: r_idx  <= '0;
            endcase
            if (w_push && w_do_off) r_v_busy[w_held_v] <= 1'b0;
            if (w_push && w_do_on) begin
                r_v_busy[w_free_v] <= 1'b1;
                r_v_key[w_free_v]  <= w_key;
                r_v_note[w_free_v] <= w_note_on;
            end
            if (w_oct_up && (r_octave != c_OCT_MAX)) r_octave <= r_octave + 3'sd1;
            if (w_oct_dn && (r_octave != c_OCT_MIN)) r_octave <= r_octave - 3'sd1;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .i_push     (w_push),
        .i_data     (w_push_data),
        .o_in_ready (w_in_ready),
        .o_valid    (w_head_valid),
        .i_ready    (evt_ready),
        .o_data     (w_head)
    );

    // Event fields are forced to zero when nothing is queued.
    always_comb begin
        busy        = w_busy;
        report_drop = r_report_drop;
        voice_full  = r_voice_full;
        octave      = r_octave;
        evt_valid   = w_head_valid;
        evt_on      = w_head.on && w_head_valid;
        evt_note    = w_head.note & {6{w_head_valid}};
        evt_voice   = w_head.voice[c_VW-1:0] & {c_VW{w_head_valid}};
        w_unused    = ^w_head;
    end

endmodule
`default_nettype wire
